pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline (IF, ID, IX, IM, IW). It sequences the pipeline registers in three cases:
- load-use hazards between ID and IX;
- PC redirects signalled from IM;
- variable-latency data-memory accesses in IM.

It drives per-register hold enables, the bubble (stall_in) inputs, a sticky memory-timeout error and a stall performance counter.

---
 rtl/pipeline_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing for load-use, redirect and memory-wait hazards
module pipeline_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int MEM_TIMEOUT  = 15,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4:0]             id_rs,
   input  logic [4:0]             id_rt,
   input  logic                   id_rs_used,
   input  logic                   id_rt_used,
   input  logic [4:0]             ix_dest,
   input  logic                   ix_write_to_reg,
   input  logic                   ix_is_load,
   input  logic                   update_pc_in,
   input  logic                   mem_req,
   input  logic                   mem_ready,
   output logic                   hold_pc,
   output logic                   hold_if_id,
   output logic                   hold_id_ix,
   output logic                   hold_ix_im,
   output logic                   flush_if_id,
   output logic                   bubble_id_ix,
   output logic                   bubble_im_iw,
   output logic                   mem_timeout,
   output logic [STALL_CNT_W-1:0] stall_cycles
);
   typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, ERR} state_t;
   localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);
   state_t     state, state_nx;
   logic [7:0] wait_cnt, wait_nx;
   logic [2:0] flush_cnt, flush_nx;
   logic       lu, stall, hold_all, hold_lu, flush_c, bub_id, bub_im;
   assign lu = ix_is_load & ix_write_to_reg & (ix_dest != 5'd0) &
               ((id_rs_used & (id_rs == ix_dest)) | (id_rt_used & (id_rt == ix_dest)));
   // once waiting, only ready releases the stall; elsewhere a new not-ready request starts one
   assign stall = (state == MEM_WAIT) ? !mem_ready : (mem_req & !mem_ready);
   // next-state and control decode, priority memory stall > redirect > load-use
   always_comb begin
      state_nx = state;
      wait_nx  = wait_cnt;
      flush_nx = flush_cnt;
      hold_all = 1'b0;
      hold_lu  = 1'b0;
      flush_c  = 1'b0;
      bub_id   = 1'b0;
      bub_im   = 1'b0;
      if (state == ERR) begin
         hold_all = 1'b1;
         bub_im   = 1'b1;
      end else if (stall) begin
         hold_all = 1'b1;
         bub_im   = 1'b1;
         wait_nx  = (state == MEM_WAIT) ? wait_cnt + 8'd1 : 8'd1;
         state_nx = (wait_nx == TMO) ? ERR : MEM_WAIT;
      end else if (state == MEM_WAIT) begin
         wait_nx  = 8'd0;
         state_nx = (flush_cnt != 3'd0) ? FLUSH : RUN;
      end else if (update_pc_in) begin
         flush_c  = 1'b1;
         bub_id   = 1'b1;
         flush_nx = FL_INIT;
         state_nx = (FL_INIT != 3'd0) ? FLUSH : RUN;
      end else if (state == FLUSH) begin
         flush_c  = 1'b1;
         bub_id   = 1'b1;
         flush_nx = flush_cnt - 3'd1;
         state_nx = (flush_cnt == 3'd1) ? RUN : FLUSH;
      end else if (lu) begin
         hold_lu  = 1'b1;
         bub_id   = 1'b1;
      end
   end
   assign hold_pc      = rst_n & (hold_all | hold_lu);
   assign hold_if_id   = rst_n & (hold_all | hold_lu);
   assign hold_id_ix   = rst_n & hold_all;
   assign hold_ix_im   = rst_n & hold_all;
   assign flush_if_id  = rst_n & flush_c;
   assign bubble_id_ix = rst_n & bub_id;
   assign bubble_im_iw = rst_n & bub_im;
   assign mem_timeout  = rst_n & (state == ERR);
   // state, counters and saturating stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RUN;
         wait_cnt     <= 8'd0;
         flush_cnt    <= 3'd0;
         stall_cycles <= '0;
      end else begin
         state        <= state_nx;
         wait_cnt     <= wait_nx;
         flush_cnt    <= flush_nx;
         stall_cycles <= (hold_pc && !(&stall_cycles)) ? stall_cycles + STALL_CNT_W'(1) : stall_cycles;
      end
   end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks against a behavioural hazard model
module tb_pipeline_hazard_ctrl;
   localparam int FC = 2;
   localparam int MT = 15;
   localparam int W  = 16;
   logic         clk, rst_n;
   logic [4:0]   id_rs, id_rt, ix_dest;
   logic         id_rs_used, id_rt_used, ix_write_to_reg, ix_is_load;
   logic         update_pc_in, mem_req, mem_ready;
   logic         hold_pc, hold_if_id, hold_id_ix, hold_ix_im;
   logic         flush_if_id, bubble_id_ix, bubble_im_iw, mem_timeout;
   logic [W-1:0] stall_cycles;
   logic [7:0]   flags;
   int           n_tests, n_fail;
   bit           dead, waiting;
   int           nr, fl, stalls;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .STALL_CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
      .id_rt_used(id_rt_used), .ix_dest(ix_dest), .ix_write_to_reg(ix_write_to_reg),
      .ix_is_load(ix_is_load), .update_pc_in(update_pc_in), .mem_req(mem_req),
      .mem_ready(mem_ready), .hold_pc(hold_pc), .hold_if_id(hold_if_id),
      .hold_id_ix(hold_id_ix), .hold_ix_im(hold_ix_im), .flush_if_id(flush_if_id),
      .bubble_id_ix(bubble_id_ix), .bubble_im_iw(bubble_im_iw), .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles));

   assign flags = {hold_pc, hold_if_id, hold_id_ix, hold_ix_im,
                   flush_if_id, bubble_id_ix, bubble_im_iw, mem_timeout};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // expected flags for the current inputs; commit advances the model by one cycle
   task automatic model(input bit commit, output logic [7:0] f);
      bit lu, st;
      lu = ix_is_load && ix_write_to_reg && ix_dest != 0 &&
           ((id_rs_used && id_rs == ix_dest) || (id_rt_used && id_rt == ix_dest));
      st = waiting ? !mem_ready : (mem_req && !mem_ready);
      f = 8'h00;
      if (dead) f = 8'b1111_0011;
      else if (st) begin
         f = 8'b1111_0010;
         if (commit) begin
            nr = waiting ? nr + 1 : 1;
            waiting = 1;
            if (nr == MT) dead = 1;
         end
      end else if (waiting) begin
         if (commit) begin
            waiting = 0;
            nr = 0;
         end
      end else if (update_pc_in) begin
         f = 8'b0000_1100;
         if (commit) fl = FC - 1;
      end else if (fl > 0) begin
         f = 8'b0000_1100;
         if (commit) fl--;
      end else if (lu) f = 8'b1100_0100;
      if (commit && f[7] && stalls < (1 << W) - 1) stalls++;
   endtask

   task automatic idle();
      {id_rs, id_rt, ix_dest} = '0;
      {id_rs_used, id_rt_used, ix_write_to_reg, ix_is_load} = '0;
      {update_pc_in, mem_req, mem_ready} = '0;
   endtask

   // entered at posedge+1 with inputs applied; leaves at the next posedge+1
   task automatic cyc(input string tag);
      logic [7:0] f;
      #2;
      model(0, f);
      check({tag, " flags"}, 32'(flags), 32'(f));
      check({tag, " stall"}, 32'(stall_cycles), 32'(stalls));
      model(1, f);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      #3;
      rst_n = 1'b0;
      #1;
      check({tag, " rst flags"}, 32'(flags), 32'h0);
      check({tag, " rst stall"}, 32'(stall_cycles), 32'h0);
      dead = 0; waiting = 0; nr = 0; fl = 0; stalls = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      cyc({tag, " post"});
   endtask

   task automatic set_lu(input logic [4:0] d, input logic used);
      ix_is_load = 1; ix_write_to_reg = 1; ix_dest = d; id_rs = 5'd8; id_rs_used = used;
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      dead = 0; waiting = 0; nr = 0; fl = 0; stalls = 0;
      rst_n = 1'b0;
      idle();
      #12;
      check("init flags", 32'(flags), 32'h0);
      check("init stall", 32'(stall_cycles), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // load-use and its non-hazard variants
      set_lu(5'd8, 1'b1); cyc("lu");
      idle(); cyc("lu next");
      check("lu count", 32'(stall_cycles), 32'd1);
      set_lu(5'd0, 1'b1); cyc("lu r0");
      set_lu(5'd8, 1'b0); cyc("lu unused");
      idle(); cyc("idle");
      // redirect
      update_pc_in = 1; cyc("redir");
      idle(); for (int i = 0; i < 3; i++) cyc("redir tail");
      // memory wait of three cycles
      mem_req = 1;
      for (int i = 0; i < 3; i++) cyc("mwait");
      mem_ready = 1; cyc("mready");
      idle(); cyc("mdone");
      // timeout, then stuck in error even once ready rises
      mem_req = 1;
      for (int i = 0; i < MT; i++) cyc("tmo");
      check("tmo flag", 32'(mem_timeout), 32'd1);
      for (int i = 0; i < 20; i++) begin
         mem_ready = (i >= 10);
         cyc("err");
      end
      do_reset("err");
      // simultaneous stall, redirect and load-use
      mem_req = 1; update_pc_in = 1; set_lu(5'd8, 1'b1);
      for (int i = 0; i < 2; i++) cyc("simul wait");
      mem_ready = 1; cyc("simul ready");
      mem_req = 0; mem_ready = 0; cyc("simul redir");
      idle(); for (int i = 0; i < 3; i++) cyc("simul tail");
      // memory stall arriving in the first flush cycle
      update_pc_in = 1; cyc("pre flush");
      update_pc_in = 0; mem_req = 1; cyc("flush stall");
      mem_ready = 1; cyc("flush ready");
      idle(); for (int i = 0; i < 3; i++) cyc("flush resume");
      // reset mid-flush and mid-wait
      update_pc_in = 1; cyc("r flush");
      update_pc_in = 0;
      do_reset("in flush");
      mem_req = 1; cyc("r wait"); cyc("r wait2");
      do_reset("in wait");
      // random traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         ix_dest = 5'($urandom_range(0, 3));
         id_rs_used = 1'($urandom);
         id_rt_used = 1'($urandom);
         ix_write_to_reg = 1'($urandom);
         ix_is_load = 1'($urandom);
         update_pc_in = ($urandom_range(0, 99) < 15);
         mem_req = ($urandom_range(0, 99) < 30);
         mem_ready = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 149) == 0) do_reset("rand");
         else cyc("rand");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
